soc1_sysid_checker: RTL and testbench

SOC1_SYSID_CHECKER -- requirements
Module: soc1_sysid_checker

---
 rtl/soc1_sysid_pkg.sv | 23 ++
 rtl/soc1_sysid_timer.sv | 37 +++
 rtl/soc1_sysid_checker.sv | 161 ++++++++++++++++
 tb/tb_soc1_sysid_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc1_sysid_pkg.sv
// Shared types and constants for the sysid checker.
// State encoding and Avalon word addresses of the sysid slave.
package soc1_sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ID   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_RD_TS   = 3'd3,
    S_WAIT_TS = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // States in which a read transaction is outstanding
  function automatic logic in_xfer(state_t s);
    return (s == S_RD_ID)   || (s == S_WAIT_ID) ||
           (s == S_RD_TS)   || (s == S_WAIT_TS);
  endfunction

endpackage

// File: rtl/soc1_sysid_timer.sv
// Per-transaction cycle counter for the sysid checker.
// tc fires in the last allowed cycle of a read transaction.
module soc1_sysid_timer #(
  parameter logic [15:0] LIMIT = 16'd1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Clear has priority so a new transaction always starts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && (cnt_q == (LIMIT - 16'd1));

endmodule

// File: rtl/soc1_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM
// and compares them against the expected build values.
module soc1_sysid_checker
  import soc1_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1730297491,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_t      state_q;
  state_t      state_d;
  logic        auto_q;
  logic        auto_d;
  logic        id_ok_q;
  logic        id_ok_d;
  logic        ts_ok_q;
  logic        ts_ok_d;
  logic        timeout_q;
  logic        timeout_d;
  logic [31:0] id_value_q;
  logic [31:0] id_value_d;
  logic [31:0] ts_value_q;
  logic [31:0] ts_value_d;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;

  soc1_sysid_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .tc      (tmr_tc)
  );

  assign tmr_en = in_xfer(state_q);

  // Next-state, bus command and result-flag logic
  always_comb begin
    state_d     = state_q;
    auto_d      = 1'b0;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    tmr_clr     = 1'b0;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d   = S_RD_ID;
          tmr_clr   = 1'b1;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_RD_ID: begin
        avm_read    = 1'b1;
        avm_address = ADDR_ID;
        if (tmr_tc) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end else if (!avm_waitrequest) begin
          state_d = S_WAIT_ID;
        end
      end
      S_WAIT_ID: begin
        if (avm_readdatavalid) begin
          state_d    = S_RD_TS;
          tmr_clr    = 1'b1;
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
        end else if (tmr_tc) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end
      end
      S_RD_TS: begin
        avm_read    = 1'b1;
        avm_address = ADDR_TS;
        if (tmr_tc) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end else if (!avm_waitrequest) begin
          state_d = S_WAIT_TS;
        end
      end
      S_WAIT_TS: begin
        if (avm_readdatavalid) begin
          state_d    = S_FINISH;
          ts_value_d = avm_readdata;
          ts_ok_d    = (avm_readdata == EXPECTED_TS);
        end else if (tmr_tc) begin
          state_d   = S_FINISH;
          timeout_d = 1'b1;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      auto_q     <= AUTO_START;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_soc1_sysid_checker.sv
// Bench for soc1_sysid_checker: scripted Avalon slave
// with random wait/latency against a timing/result model.
module tb_soc1_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1730297491;
  localparam int          TMO    = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  soc1_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (16'(TMO)),
    .AUTO_START     (1'b1)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .id_ok             (id_ok),
    .ts_ok             (ts_ok),
    .timeout           (timeout),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_read"}, avm_read, 1'b0);
    chk({tag, "_addr"}, avm_address, 1'b0);
    chk({tag, "_id_ok"}, id_ok, 1'b0);
    chk({tag, "_ts_ok"}, ts_ok, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_id_value"}, id_value, 32'd0);
    chk({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  // Called at a negedge. Cycle 0 is the start (or auto-start)
  // cycle; the slave answers ID/TS reads after w stall cycles
  // and returns data l cycles after acceptance.
  task automatic run_check(input int w1, input int l1,
                           input logic [31:0] d1,
                           input int w2, input int l2,
                           input logic [31:0] d2,
                           input bit nores,
                           input bit use_start,
                           input int restart_at,
                           input bit late);
    int   cyc = 0;
    int   done_at = -1;
    int   rd_cycles = 0;
    int   dly = 0;
    int   w;
    int   exp_done;
    logic rd_addr = 1'b0;
    logic cur_addr = 1'b0;
    bit   busy_bad = 1'b0;
    bit   stab_bad = 1'b0;
    bit   idle_bad = 1'b0;

    if (nores) exp_done = 1 + (w1 + 1 + l1) + TMO;
    else       exp_done = 1 + (w1 + 1 + l1) + (w2 + 1 + l2);

    start             = use_start;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = late;
    avm_readdata      = late ? 32'hBAD0BAD0 : $urandom;

    while (done_at < 0 && cyc < 80) begin
      @(negedge clock);
      cyc++;
      start             = (cyc == restart_at);
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (late && cyc == 1) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hBAD1BAD1;
      end
      if (dly > 0) begin
        dly--;
        if (dly == 0 && !(nores && rd_addr)) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rd_addr ? d2 : d1;
        end
      end
      if (avm_read) begin
        if (rd_cycles == 0) cur_addr = avm_address;
        else if (avm_address !== cur_addr) stab_bad = 1'b1;
        rd_cycles++;
        w = avm_address ? w2 : w1;
        if (rd_cycles <= w) begin
          avm_waitrequest = 1'b1;
        end else begin
          avm_waitrequest = 1'b0;
          dly     = avm_address ? l2 : l1;
          rd_addr = avm_address;
          if (avm_address) chk("rd_ts_cycles", rd_cycles, w2 + 1);
          else             chk("rd_id_cycles", rd_cycles, w1 + 1);
          rd_cycles = 0;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (done === 1'b1) done_at = cyc;
    end

    chk("done_seen", (done_at >= 0), 1'b1);
    chk("latency", done_at + 1, exp_done + 1);
    chk("busy_during", busy_bad, 1'b0);
    chk("cmd_stable", stab_bad, 1'b0);

    m_id = d1;
    if (!nores) m_ts = d2;
    chk("id_ok", id_ok, (d1 == EXP_ID));
    chk("ts_ok", ts_ok, (!nores && d2 == EXP_TS));
    chk("timeout", timeout, nores);
    chk("id_value", id_value, m_id);
    chk("ts_value", ts_value, m_ts);

    start             = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (busy !== 1'b0) idle_bad = 1'b1;
    end
    chk("no_requeue", idle_bad, 1'b0);
  endtask

  initial begin
    reset_n           = 1'b0;
    start             = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdata      = 32'd0;
    avm_readdatavalid = 1'b0;
    repeat (2) @(negedge clock);
    chk_zero_outputs("rst");

    // Auto-start check after reset release
    reset_n = 1'b1;
    run_check(0, 1, EXP_ID, 0, 1, EXP_TS, 1'b0, 1'b0, 0, 1'b0);

    // Stalled ID read
    run_check(3, 1, EXP_ID, 0, 1, EXP_TS, 1'b0, 1'b1, 0, 1'b0);

    // Wrong timestamp
    run_check(0, 1, EXP_ID, 0, 1, 32'h12345678,
              1'b0, 1'b1, 0, 1'b0);

    // Timestamp never returned
    run_check(0, 1, EXP_ID, 1, 1, EXP_TS, 1'b1, 1'b1, 0, 1'b0);

    // Start pulsed while busy
    run_check(1, 2, 32'hCAFE0001, 2, 2, EXP_TS,
              1'b0, 1'b1, 3, 1'b0);

    // Reset dropped while waiting for ID data
    start = 1'b1;
    @(negedge clock);
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clock);
    chk("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    m_id = 32'd0;
    m_ts = 32'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    run_check(0, 1, EXP_ID, 0, 1, EXP_TS, 1'b0, 1'b0, 0, 1'b1);

    // Randomised checks
    for (int it = 0; it < 24; it++) begin
      int          gw1;
      int          gl1;
      int          gw2;
      int          gl2;
      int          rs;
      logic [31:0] gd1;
      logic [31:0] gd2;
      gw1 = $urandom_range(0, 2);
      gl1 = $urandom_range(1, 2);
      gw2 = $urandom_range(0, 2);
      gl2 = $urandom_range(1, 2);
      gd1 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      gd2 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      rs  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 4) : 0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_check(gw1, gl1, gd1, gw2, gl2, gd2,
                1'b0, 1'b1, rs, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
